huffman_rle_decoder: RTL

Parametrised successor to the activation Huffman decoder. It adds configurable data width, an optional zero-run-length code and ready/valid handshakes on both sides. The block sits between the compressed activation bit-stream buffer and the activation write port. It consumes one serial bit per accepted beat and produces one DATA_W-bit word per output handshake.

---
 rtl/huffman_pkg.sv | 26 ++
 rtl/huffman_out_reg.sv | 52 +++++
 rtl/huffman_rle_decoder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/huffman_pkg.sv
// Shared types and constants for the Huffman/zero-run activation decoder.
//   state_e    : decoder FSM states
//   PFX_*      : code prefixes (MSB first)
//   cnt_width  : width of the field-bit counter for given literal/run widths
package huffman_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPfx2,
        StLit,
        StRunLen,
        StEmitRun
    } state_e;

    localparam logic [1:0] PFX_ZERO = 2'b00;
    localparam logic [1:0] PFX_RUN  = 2'b01;
    localparam logic       PFX_LIT  = 1'b1;

    function automatic int unsigned cnt_width(input int unsigned data_w,
                                              input int unsigned run_w);
        int unsigned m;
        m = (data_w > run_w) ? data_w : run_w;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/huffman_out_reg.sv
// One-entry output holding register with ready/valid handshake.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i        : capture load_data_i (only asserted while out_free_o=1)
//   load_data_i   : word to present
//   out_valid_o   : data_o valid, held until out_ready_i
//   out_ready_i   : downstream accept
//   data_o        : held word, stable while stalled
//   out_free_o    : register can take a new word this cycle
module huffman_out_reg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              out_ready_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              out_free_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    assign out_free_o = !valid_q | out_ready_i;

    // A load in the handshake cycle keeps valid high (back-to-back words).
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = load_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign data_o      = data_q;

endmodule

// File: rtl/huffman_rle_decoder.sv
// Serial Huffman decoder with optional zero-run code, ready/valid on both sides.
//   clk_i, rst_ni : clock, async active-low reset
//   flush_i       : synchronous abort of the partial symbol / pending run
//   in_bit_i      : serial code bit, accepted on in_valid_i & in_ready_o
//   data_out_o    : decoded word, valid with out_valid_o until out_ready_i
//   busy_o        : partial symbol, pending run or unaccepted output exists
module huffman_rle_decoder
    import huffman_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter bit          RUN_EN = 1'b1,
    parameter int unsigned RUN_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_bit_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] data_out_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              busy_o
);

    localparam int unsigned SHW   = (DATA_W > RUN_W) ? DATA_W : RUN_W;
    localparam int unsigned CNT_W = cnt_width(DATA_W, RUN_W);
    localparam logic [CNT_W-1:0] LIT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_W - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SHW-2:0]    shift_q, shift_d;  // current bit completes the field
    logic [RUN_W:0]    rem_q, rem_d;      // one extra bit: run of 2^RUN_W zeros
    logic [SHW-1:0]    shifted;
    logic              accept, out_free, load;
    logic [DATA_W-1:0] load_data;

    assign shifted = {shift_q, in_bit_i};
    assign accept  = in_valid_i & in_ready_o;

    // Stall the input only when the accepted bit would need the output register.
    always_comb begin
        in_ready_o = 1'b1;
        if (flush_i) begin
            in_ready_o = 1'b0;
        end else begin
            unique case (state_q)
                StIdle:    if (!RUN_EN) in_ready_o = out_free;
                StPfx2:    in_ready_o = out_free;
                StLit:     if (cnt_q == LIT_LAST) in_ready_o = out_free;
                StEmitRun: in_ready_o = 1'b0;
                default:   in_ready_o = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        rem_d     = rem_q;
        load      = 1'b0;
        load_data = '0;
        if (flush_i) begin
            state_d = StIdle;
            cnt_d   = '0;
            rem_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: if (accept) begin
                    cnt_d = '0;
                    if (in_bit_i == PFX_LIT) state_d = StLit;
                    else if (RUN_EN)         state_d = StPfx2;
                    else                     load    = 1'b1;
                end
                StPfx2: if (accept) begin
                    cnt_d = '0;
                    if ({1'b0, in_bit_i} == PFX_RUN) begin
                        state_d = StRunLen;
                    end else begin
                        load    = 1'b1;
                        state_d = StIdle;
                    end
                end
                StLit: if (accept) begin
                    shift_d = shifted[SHW-2:0];
                    if (cnt_q == LIT_LAST) begin
                        load      = 1'b1;
                        load_data = shifted[DATA_W-1:0];
                        cnt_d     = '0;
                        state_d   = StIdle;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StRunLen: if (accept) begin
                    shift_d = shifted[SHW-2:0];
                    if (cnt_q == RUN_LAST) begin
                        rem_d   = {1'b0, shifted[RUN_W-1:0]} + (RUN_W + 1)'(1);
                        cnt_d   = '0;
                        state_d = StEmitRun;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StEmitRun: if (out_free) begin
                    load  = 1'b1;
                    rem_d = rem_q - (RUN_W + 1)'(1);
                    if (rem_q == (RUN_W + 1)'(1)) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shift_q <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            rem_q   <= rem_d;
        end
    end

    huffman_out_reg #(
        .DATA_W(DATA_W)
    ) u_out_reg (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (load),
        .load_data_i(load_data),
        .out_ready_i(out_ready_i),
        .out_valid_o(out_valid_o),
        .data_o     (data_out_o),
        .out_free_o (out_free)
    );

    assign busy_o = (state_q != StIdle) | out_valid_o;

endmodule
